// File: rtl/div_unit_e_if.sv
// Execute-stage divider bus: operands and control in from the D/E register,
// stall request and result back out to the hazard unit and result mux.
interface div_unit_e_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int FUNCT3_WIDTH  = 3
);
  logic                     StartE;
  logic                     FlushE;
  logic [FUNCT3_WIDTH-1:0]  funct3E;
  logic [DATA_WIDTH-1:0]    SrcAE;
  logic [DATA_WIDTH-1:0]    SrcBE;
  logic [ADDRESS_WIDTH-1:0] RdE;
  logic                     DivBusyE;
  logic                     DivDoneE;
  logic [DATA_WIDTH-1:0]    DivResultE;
  logic [ADDRESS_WIDTH-1:0] DivRdE;

  // Pipeline side: issues operations, consumes stall and result.
  modport master (
    output StartE, FlushE, funct3E, SrcAE, SrcBE, RdE,
    input  DivBusyE, DivDoneE, DivResultE, DivRdE
  );

  // Divider side.
  modport slave (
    input  StartE, FlushE, funct3E, SrcAE, SrcBE, RdE,
    output DivBusyE, DivDoneE, DivResultE, DivRdE
  );
endinterface

// File: rtl/div_unit_e.sv
// Iterative RV32M divide/remainder unit: radix-2 restoring divider producing
// one quotient bit per cycle, with single-cycle divide-by-zero and overflow.
module div_unit_e #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int FUNCT3_WIDTH  = 3
) (
  input logic        CLK,
  input logic        RST,
  div_unit_e_if.slave bus
);

  localparam int CntW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MinVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    rem_q, rem_d;
  logic [DATA_WIDTH-1:0]    quo_q, quo_d;
  logic [DATA_WIDTH-1:0]    dvsr_q, dvsr_d;
  logic                     neg_quo_q, neg_quo_d;
  logic                     neg_rem_q, neg_rem_d;
  logic                     sel_rem_q, sel_rem_d;
  logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0]    res_q, res_d;
  logic [ADDRESS_WIDTH-1:0] rd_out_q, rd_out_d;

  // funct3[2] is always 1 for M-extension divides; decode happens upstream.
  logic unused_funct3_msb;
  assign unused_funct3_msb = bus.funct3E[FUNCT3_WIDTH-1];

  // Operand sign handling: funct3[0] = 0 selects signed ops.
  logic                  is_signed;
  logic                  a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  assign is_signed = ~bus.funct3E[0];
  assign a_neg     = is_signed & bus.SrcAE[DATA_WIDTH-1];
  assign b_neg     = is_signed & bus.SrcBE[DATA_WIDTH-1];
  assign a_mag     = a_neg ? -bus.SrcAE : bus.SrcAE;
  assign b_mag     = b_neg ? -bus.SrcBE : bus.SrcBE;

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
  logic [DATA_WIDTH:0]   rem_sh;
  logic                  trial_ge;
  logic                  unused_diff_msb;
  logic [DATA_WIDTH-1:0] diff_lo;
  logic [DATA_WIDTH-1:0] step_rem, step_quo;
  assign rem_sh   = {rem_q, quo_q[DATA_WIDTH-1]};
  assign trial_ge = rem_sh >= {1'b0, dvsr_q};
  // rem_q < dvsr_q keeps an accepted difference within DATA_WIDTH bits.
  assign {unused_diff_msb, diff_lo} = rem_sh - {1'b0, dvsr_q};
  assign step_rem = trial_ge ? diff_lo : rem_sh[DATA_WIDTH-1:0];
  assign step_quo = {quo_q[DATA_WIDTH-2:0], trial_ge};

  // Next-state, datapath loads and stall/done outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvsr_d       = dvsr_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    sel_rem_d    = sel_rem_q;
    rd_d         = rd_q;
    res_d        = res_q;
    rd_out_d     = rd_out_q;
    bus.DivBusyE = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Combinational so the stall lands in the start cycle itself.
        bus.DivBusyE = bus.StartE;
        if (bus.StartE && !bus.FlushE) begin
          sel_rem_d = bus.funct3E[1];
          rd_d      = bus.RdE;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (bus.SrcBE == '0) begin
            res_d    = bus.funct3E[1] ? bus.SrcAE : '1;
            rd_out_d = bus.RdE;
            state_d  = StDone;
          end else if (is_signed && bus.SrcAE == MinVal && bus.SrcBE == '1) begin
            res_d    = bus.funct3E[1] ? '0 : MinVal;
            rd_out_d = bus.RdE;
            state_d  = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvsr_d  = b_mag;
            cnt_d   = CntW'(DATA_WIDTH - 1);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        bus.DivBusyE = 1'b1;
        if (bus.FlushE) begin
          state_d = StIdle;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == '0) begin
            if (sel_rem_q) res_d = neg_rem_q ? -step_rem : step_rem;
            else           res_d = neg_quo_q ? -step_quo : step_quo;
            rd_out_d = rd_q;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StDone: begin
        // The stalled instruction is still in E; never restart from here.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.DivDoneE   = (state_q == StDone);
  assign bus.DivResultE = res_q;
  assign bus.DivRdE     = rd_out_q;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      rd_q      <= '0;
      res_q     <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
      rd_q      <= rd_d;
      res_q     <= res_d;
      rd_out_q  <= rd_out_d;
    end
  end

endmodule

// File: tb/tb_div_unit_e.sv
// Directed bench for div_unit_e: result values, latency, flush, reset and
// back-to-back operation.
module tb_div_unit_e;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  div_unit_e_if bus ();

  div_unit_e dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [7:0]  lat;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs [NVec] = '{
    '{3'b100, 32'd100,        32'd7,        32'd14,         8'd33},
    '{3'b110, 32'd100,        32'd7,        32'd2,          8'd33},
    '{3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,   8'd33},
    '{3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF,   8'd33},
    '{3'b101, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC,   8'd33},
    '{3'b111, 32'hFFFFFFF9,   32'd2,        32'd1,          8'd33},
    '{3'b101, 32'h12345678,   32'd0,        32'hFFFFFFFF,   8'd1},
    '{3'b111, 32'd5,          32'd0,        32'd5,          8'd1},
    '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,   8'd1},
    '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,          8'd1},
    '{3'b100, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2,   8'd33},
    '{3'b110, 32'd100,        32'hFFFFFFF9, 32'd2,          8'd33},
    '{3'b100, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2,   8'd33},
    '{3'b110, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE,   8'd33},
    '{3'b101, 32'd5,          32'hFFFFFFFF, 32'd0,          8'd33},
    '{3'b100, 32'hFFFFFF9C,   32'd0,        32'hFFFFFFFF,   8'd1},
    '{3'b110, 32'hFFFFFF9C,   32'd0,        32'hFFFFFF9C,   8'd1}
  };

  // Issue one op with StartE held until DivDoneE; sample #1 after each negedge.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int busy_n, output int done_at,
                       output logic [31:0] res, output logic [4:0] rdo);
    @(negedge CLK);
    bus.funct3E = f;
    bus.SrcAE   = a;
    bus.SrcBE   = b;
    bus.RdE     = rd;
    bus.StartE  = 1'b1;
    busy_n  = 0;
    done_at = -1;
    res     = '0;
    rdo     = '0;
    for (int c = 0; c < 45; c++) begin
      #1;
      if (bus.DivBusyE) busy_n++;
      if (bus.DivDoneE) begin
        done_at = c;
        res     = bus.DivResultE;
        rdo     = bus.DivRdE;
        break;
      end
      @(negedge CLK);
    end
    bus.StartE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          busy_n, done_at, n_done, d0, d1;
    logic [31:0] res;
    logic [4:0]  rdo;

    RST         = 1'b1;
    bus.StartE  = 1'b0;
    bus.FlushE  = 1'b0;
    bus.funct3E = '0;
    bus.SrcAE   = '0;
    bus.SrcBE   = '0;
    bus.RdE     = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("reset busy", 32'(bus.DivBusyE), 32'd0);
    check("reset done", 32'(bus.DivDoneE), 32'd0);
    check("reset result", bus.DivResultE, 32'd0);
    check("reset rd", 32'(bus.DivRdE), 32'd0);

    // Directed vector table.
    for (int i = 0; i < NVec; i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), busy_n, done_at, res, rdo);
      check($sformatf("v%0d result", i), res, vecs[i].exp);
      check($sformatf("v%0d rd", i), 32'(rdo), 32'(i + 1));
      check($sformatf("v%0d done cycle", i), 32'(done_at), 32'(vecs[i].lat));
      check($sformatf("v%0d busy cycles", i), 32'(busy_n), 32'(vecs[i].lat));
      @(negedge CLK);
      #1;
      check($sformatf("v%0d single pulse", i), 32'(bus.DivDoneE), 32'd0);
      check($sformatf("v%0d result hold", i), bus.DivResultE, vecs[i].exp);
    end

    // Flush in CALC cycle 10: no DONE, result register untouched.
    @(negedge CLK);
    bus.funct3E = 3'b100;
    bus.SrcAE   = 32'd100;
    bus.SrcBE   = 32'd7;
    bus.RdE     = 5'd20;
    bus.StartE  = 1'b1;
    repeat (10) @(negedge CLK);
    bus.FlushE = 1'b1;
    bus.StartE = 1'b0;
    @(negedge CLK);
    bus.FlushE = 1'b0;
    #1;
    check("flush busy", 32'(bus.DivBusyE), 32'd0);
    check("flush done", 32'(bus.DivDoneE), 32'd0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      #1;
      if (bus.DivDoneE) n_done++;
    end
    check("flush no done", 32'(n_done), 32'd0);
    check("flush result kept", bus.DivResultE, vecs[NVec-1].exp);
    do_op(3'b100, 32'd9, 32'd3, 5'd9, busy_n, done_at, res, rdo);
    check("post-flush result", res, 32'd3);
    check("post-flush done cycle", 32'(done_at), 32'd33);
    check("post-flush rd", 32'(rdo), 32'd9);

    // Back-to-back with StartE held continuously.
    @(negedge CLK);
    bus.funct3E = 3'b100;
    bus.SrcAE   = 32'd100;
    bus.SrcBE   = 32'd7;
    bus.RdE     = 5'd3;
    bus.StartE  = 1'b1;
    n_done = 0;
    d0 = -1;
    d1 = -1;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (bus.DivDoneE) begin
        if (n_done == 0) d0 = c;
        else if (n_done == 1) d1 = c;
        n_done++;
        check($sformatf("b2b result %0d", n_done), bus.DivResultE, 32'd14);
        if (n_done == 2) bus.StartE = 1'b0;
      end
      @(negedge CLK);
    end
    bus.StartE = 1'b0;
    check("b2b pulses", 32'(n_done), 32'd2);
    check("b2b first done", 32'(d0), 32'd33);
    check("b2b second done", 32'(d1), 32'd67);

    // Reset in CALC cycle 20.
    @(negedge CLK);
    bus.funct3E = 3'b101;
    bus.SrcAE   = 32'd1000;
    bus.SrcBE   = 32'd10;
    bus.RdE     = 5'd17;
    bus.StartE  = 1'b1;
    repeat (20) @(negedge CLK);
    RST        = 1'b1;
    bus.StartE = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("mid reset busy", 32'(bus.DivBusyE), 32'd0);
    check("mid reset done", 32'(bus.DivDoneE), 32'd0);
    check("mid reset result", bus.DivResultE, 32'd0);
    check("mid reset rd", 32'(bus.DivRdE), 32'd0);
    do_op(3'b101, 32'd1000, 32'd10, 5'd17, busy_n, done_at, res, rdo);
    check("post-reset result", res, 32'd100);
    check("post-reset done cycle", 32'(done_at), 32'd33);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_unit_e.md
Name: div_unit_e

Overview:
- Iterative RV32M divide/remainder unit in the execute stage.
- Consumes the operands, funct3 and destination register that the decode/execute pipeline register presents in E.
- Returns the result to the execute-stage result path and raises a stall request to the hazard unit while it iterates.
- Radix-2 restoring divider: one quotient bit per cycle, with single-cycle handling of the divide-by-zero and signed-overflow special cases.

Parameters:
DATA_WIDTH, 32, operand/result width
ADDRESS_WIDTH, 5, register index width
FUNCT3_WIDTH, 3, funct3 width

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, synchronous, active-high
StartE  input  1  E-stage instruction is DIV/DIVU/REM/REMU (decoded upstream)
FlushE  input  1  abort in-flight operation (same flush as D/E register clear)
funct3E  input  FUNCT3_WIDTH  100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcAE  input  DATA_WIDTH  dividend (post-forwarding)
SrcBE  input  DATA_WIDTH  divisor (post-forwarding)
RdE  input  ADDRESS_WIDTH  destination register
DivBusyE  output  1  stall request to hazard unit
DivDoneE  output  1  result valid, one-cycle pulse
DivResultE  output  DATA_WIDTH  quotient or remainder
DivRdE  output  ADDRESS_WIDTH  destination of DivResultE

Behaviour:
Reset and flush:
- Clock is CLK only. Reset is synchronous, active-high on RST.
- RST forces: state IDLE, DivDoneE 0, DivResultE 0, DivRdE 0, iteration counter 0. DivBusyE is 0 in the cycle after reset.
- Priority: RST > FlushE > normal operation.

States:
- IDLE: DivBusyE = StartE (combinational, so the stall lands in the start cycle).
  - On StartE at the edge, capture funct3, RdE, and the operand signs and magnitudes:
    - signed ops (funct3[0]=0): |SrcAE|, |SrcBE|;
    - unsigned ops: raw values.
  - Divisor == 0: go to DONE with quotient all-ones, remainder = SrcAE.
  - Signed op with SrcAE = 0x80000000 and SrcBE = 0xFFFFFFFF: go to DONE with quotient 0x80000000, remainder 0.
  - Otherwise: go to CALC with counter = DATA_WIDTH-1.
- CALC: DivBusyE = 1.
  - Each cycle: shift {remainder, quotient} left by 1, trial-subtract divisor from the remainder, keep the result if non-negative and set the quotient LSB.
  - Trial subtract is DATA_WIDTH+1 bits wide.
  - At counter = 0, go to DONE; otherwise decrement the counter.
  - FlushE = 1: go to IDLE, no DONE.
- DONE: DivBusyE = 0, DivDoneE = 1.
  - DivResultE and DivRdE are registered on entry to DONE.
  - Quotient is negated if signed and operand signs differ.
  - Remainder is negated if signed and dividend is negative.
  - funct3[1] selects remainder (1) or quotient (0).
  - Always returns to IDLE next cycle. StartE is ignored in DONE: the stalled instruction is still in E and must not restart.
  - FlushE in DONE has no effect on that cycle's outputs.

Latency and holds:
- Normal operation: start edge at cycle 0, CALC cycles 1..32, DONE at cycle 33 (DivBusyE high cycles 0..32).
- Special cases: DONE at cycle 1, DivBusyE high for cycle 0 only.
- DivResultE and DivRdE hold their value until the next DONE entry or RST.
- Back-to-back divides: a new StartE seen in IDLE the cycle after DONE starts a fresh operation.
- FlushE in IDLE with StartE = 1: no start.

Test Plan:
- DIV 100/7 with StartE held -> DivBusyE high 33 cycles, DivDoneE pulse at cycle 33, DivResultE=14, DivRdE=RdE; REM same operands -> 2.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- DIVU 0x12345678/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; both DivDoneE at cycle 1, DivBusyE high only cycle 0.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DivDoneE at cycle 1.
- FlushE at CALC cycle 10 -> IDLE next cycle, DivBusyE 0, no DivDoneE; new DIV 9/3 then completes with 3 at cycle 33 after its start.
- Two DIVs back-to-back (StartE continuously high) -> DivDoneE at cycles 33 and 67, exactly one pulse each. Separately: RST at CALC cycle 20 -> all outputs 0 next cycle, state IDLE.
